netlist_bist: RTL and testbench
===============================

NETLIST_BIST -- requirements
Module: netlist_bist

Interface
REQ-001 Parameter PAT_W, default 8: width of the pattern-count input and the internal pattern counter.
REQ-002 Parameter LATENCY, default 2: cycles from driving stim to a valid resp (register depth of the downstream netlist); legal range 1..8.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: reset; synchronous and active-low.
REQ-005 Port start  input  1: request a test run; sampled only in IDLE.
REQ-006 Port num_patterns  input  PAT_W: number of patterns for the run; sampled with start.
REQ-007 Port seed  input  8: LFSR seed; sampled with start.
REQ-008 Port expected_sig  input  16: golden signature; sampled in DONE.
REQ-009 Port stim  output  4: stimulus vector; bit0->in1, bit1->in2, bit2->in3, bit3->in4 of the downstream netlist.
REQ-010 Port resp  input  2: netlist response; bit0=out1, bit1=out2.
REQ-011 Port busy  output  1: high in RUN and DRAIN.
REQ-012 Port done  output  1: one-cycle pulse in DONE.
REQ-013 Port signature  output  16: MISR contents; holds its value from DONE until the next accepted start.
REQ-014 Port pass  output  1: signature==expected_sig; registered in DONE and held until the next accepted start.

Function
REQ-015 FSM states are IDLE, RUN, DRAIN and DONE.
REQ-016 IDLE with start=1 and num_patterns!=0: load LFSR with seed (8'h01 if seed==0), counter=num_patterns, signature=0, pass=0, then go to RUN.
REQ-017 IDLE with start=1 and num_patterns==0: signature=0, then go directly to DONE; no stimulus is issued.
REQ-018 RUN: stim=lfsr[3:0] each cycle; pattern 0 is driven in the first RUN cycle; LFSR advances and counter decrements every RUN cycle.
REQ-019 LFSR step is Galois: next = lfsr[0] ? (lfsr>>1)^8'hB8 : lfsr>>1.
REQ-020 RUN lasts exactly num_patterns cycles, then goes to DRAIN.
REQ-021 stim=4'h0 in IDLE, DRAIN and DONE.
REQ-022 A valid bit accompanies each issued pattern through a LATENCY-deep shift register; resp is compacted only in cycles where the delayed valid bit=1, giving exactly num_patterns compactions.
REQ-023 MISR step is next = (sig<<1) ^ (sig[15] ? 16'h1021 : 16'h0) ^ {14'b0, resp}.
REQ-024 DRAIN lasts LATENCY cycles, then goes to DONE; the last compaction occurs in the final DRAIN cycle.
REQ-025 DONE lasts one cycle: done=1, pass latched, then go to IDLE.
REQ-026 start is ignored while busy=1 or in DONE.
REQ-027 A start asserted in the same cycle the FSM returns to IDLE is honoured in the following IDLE cycle; no start is lost.
REQ-028 Counter and LFSR state are not observable outside RUN; num_patterns=2^PAT_W-1 runs without wrap.

Reset
REQ-029 rst_n=0 at a clock edge forces: state=IDLE, stim=0, busy=0, done=0, signature=0, pass=0, and the valid pipeline cleared.
REQ-030 Reset mid-RUN or mid-DRAIN aborts the run; no done pulse is produced, and the first post-reset cycle is IDLE.

Structure
REQ-031 Shared package netlist_bist_pkg holds the FSM state enum, LFSR_POLY=8'hB8, MISR_POLY=16'h1021 and LFSR_DEFAULT_SEED=8'h01.
REQ-032 The MISR is a sub-module misr16 (clk, rst_n, clr, en, d[1:0], sig[15:0]); the LFSR and FSM remain in netlist_bist.

Verification
REQ-033 seed=8'h01, num_patterns=4, start pulse -> stim sequence 1,8,C,E in RUN cycles 1-4, then 0; busy high for 4+LATENCY cycles.
REQ-034 resp tied 2'b01, num_patterns=2 -> signature=16'h0003; expected_sig=16'h0003 gives pass=1 and one done pulse; expected_sig=16'h0004 gives pass=0.
REQ-035 resp tied 0, num_patterns=255 -> signature=16'h0000 and done pulse exactly 255+LATENCY+1 cycles after start.
REQ-036 num_patterns=0, start -> DONE on the next cycle, signature=0, stim stays 0.
REQ-037 rst_n low during RUN at pattern 3 -> next cycle IDLE, stim=0, busy=0, no done; a fresh run then reproduces the REQ-033 results.
REQ-038 start held high continuously with num_patterns=1 -> back-to-back runs; start ignored while busy; each run produces one done pulse.

Source files
------------

// File: rtl/netlist_bist_pkg.sv
// Shared types and constants for the netlist BIST controller.
// Holds the FSM state encoding and the LFSR/MISR polynomials.
package netlist_bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [7:0]  LFSR_POLY         = 8'hB8;
    localparam logic [15:0] MISR_POLY         = 16'h1021;
    localparam logic [7:0]  LFSR_DEFAULT_SEED = 8'h01;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
    endfunction

    function automatic logic [15:0] misr_step(
        input logic [15:0] s,
        input logic [1:0]  d
    );
        return (s << 1) ^ (s[15] ? MISR_POLY : 16'h0) ^ {14'b0, d};
    endfunction

endpackage

// File: rtl/misr16.sv
// 16-bit multiple-input signature register compacting a 2-bit response.
// clr has priority over en; both are synchronous.
module misr16
    import netlist_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [1:0]  d,
    output logic [15:0] sig
);

    logic [15:0] r_sig;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (clr) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= misr_step(r_sig, d);
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/netlist_bist.sv
// BIST controller: LFSR stimulus into a pipelined netlist, MISR compaction
// of its response, and a golden-signature compare at the end of each run.
module netlist_bist
    import netlist_bist_pkg::*;
#(
    parameter int PAT_W   = 8,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] num_patterns,
    input  logic [7:0]       seed,
    input  logic [15:0]      expected_sig,
    output logic [3:0]       stim,
    input  logic [1:0]       resp,
    output logic             busy,
    output logic             done,
    output logic [15:0]      signature,
    output logic             pass
);

    localparam logic [2:0] DRAIN_LAST = 3'(LATENCY - 1);

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_lfsr;
    logic [PAT_W-1:0]   r_cnt;
    logic [LATENCY-1:0] r_vld;
    logic [2:0]         r_dcnt;
    logic               r_pass;

    logic w_accept;
    logic w_run;
    logic w_match;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_run    = (r_state == S_RUN);
    assign w_match  = (signature == expected_sig);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (num_patterns == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == PAT_W'(1)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_dcnt == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_lfsr  <= LFSR_DEFAULT_SEED;
            r_cnt   <= '0;
            r_vld   <= '0;
            r_dcnt  <= '0;
            r_pass  <= 1'b0;
        end else begin
            r_state  <= w_next;
            // Valid bit travels alongside each pattern through the netlist.
            r_vld[0] <= w_run;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            if (w_accept) begin
                r_lfsr <= (seed == 8'h00) ? LFSR_DEFAULT_SEED : seed;
                r_cnt  <= num_patterns;
                r_pass <= 1'b0;
            end else if (w_run) begin
                r_lfsr <= lfsr_step(r_lfsr);
                r_cnt  <= r_cnt - PAT_W'(1);
            end
            if (w_run && (w_next == S_DRAIN)) begin
                r_dcnt <= DRAIN_LAST;
            end else if (r_state == S_DRAIN) begin
                r_dcnt <= r_dcnt - 3'd1;
            end
            if (r_state == S_DONE) begin
                r_pass <= w_match;
            end
        end
    end

    misr16 u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_accept),
        .en    (r_vld[LATENCY-1]),
        .d     (resp),
        .sig   (signature)
    );

    assign stim = w_run ? r_lfsr[3:0] : 4'h0;
    assign busy = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done = (r_state == S_DONE);
    assign pass = (r_state == S_DONE) ? w_match : r_pass;

endmodule

// File: tb/tb_netlist_bist.sv
// Directed self-checking bench for netlist_bist with a 2-deep netlist model.
// Netlist model: out1 = in1 ^ in2, out2 = in3 & in4.
module tb_netlist_bist;

    localparam int PAT_W = 8;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [PAT_W-1:0] num_patterns = '0;
    logic [7:0]       seed = 8'h00;
    logic [15:0]      expected_sig = 16'h0000;
    logic [3:0]       stim;
    logic [1:0]       resp;
    logic             busy;
    logic             done;
    logic [15:0]      signature;
    logic             pass;

    logic       use_net = 1'b0;
    logic [1:0] resp_tie = 2'b00;
    logic [1:0] r_p1 = 2'b00;
    logic [1:0] r_p2 = 2'b00;

    int total = 0;
    int fails = 0;

    netlist_bist #(
        .PAT_W   (PAT_W),
        .LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_patterns (num_patterns),
        .seed         (seed),
        .expected_sig (expected_sig),
        .stim         (stim),
        .resp         (resp),
        .busy         (busy),
        .done         (done),
        .signature    (signature),
        .pass         (pass)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        r_p1 <= {stim[2] & stim[3], stim[0] ^ stim[1]};
        r_p2 <= r_p1;
    end

    assign resp = use_net ? r_p2 : resp_tie;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_done(input int c0, input int limit,
                               output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < limit) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        int c;
        int nd;
        int nb;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        chk("rst_stim", 32'(stim), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_sig", 32'(signature), 32'h0);
        chk("rst_pass", 32'(pass), 32'h0);
        rst_n = 1'b1;
        step();

        // Seed 1, four patterns through the netlist model
        use_net      = 1'b1;
        seed         = 8'h01;
        num_patterns = 8'd4;
        expected_sig = 16'h000F;
        start        = 1'b1;
        step();
        start = 1'b0;
        chk("a_stim0", 32'(stim), 32'h1);
        chk("a_busy0", 32'(busy), 32'h1);
        step();
        chk("a_stim1", 32'(stim), 32'h8);
        step();
        chk("a_stim2", 32'(stim), 32'hC);
        step();
        chk("a_stim3", 32'(stim), 32'hE);
        step();
        chk("a_drain1_stim", 32'(stim), 32'h0);
        chk("a_drain1_busy", 32'(busy), 32'h1);
        step();
        chk("a_drain2_busy", 32'(busy), 32'h1);
        chk("a_drain2_done", 32'(done), 32'h0);
        step();
        chk("a_done", 32'(done), 32'h1);
        chk("a_done_busy", 32'(busy), 32'h0);
        chk("a_sig", 32'(signature), 32'h000F);
        chk("a_pass", 32'(pass), 32'h1);
        step();
        chk("a_done_pulse", 32'(done), 32'h0);
        chk("a_pass_hold", 32'(pass), 32'h1);
        chk("a_sig_hold", 32'(signature), 32'h000F);

        // resp tied 01, two patterns, matching golden
        use_net      = 1'b0;
        resp_tie     = 2'b01;
        seed         = 8'h33;
        num_patterns = 8'd2;
        expected_sig = 16'h0003;
        start        = 1'b1;
        step();
        start = 1'b0;
        run_to_done(1, 20, c);
        chk("b_done", 32'(done), 32'h1);
        chk("b_sig", 32'(signature), 32'h0003);
        chk("b_pass", 32'(pass), 32'h1);
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done) nd++;
        end
        chk("b_extra_done", 32'(nd), 32'h0);

        // Same run, mismatching golden
        expected_sig = 16'h0004;
        start        = 1'b1;
        step();
        start = 1'b0;
        chk("b2_pass_clr", 32'(pass), 32'h0);
        run_to_done(1, 20, c);
        chk("b2_done", 32'(done), 32'h1);
        chk("b2_sig", 32'(signature), 32'h0003);
        chk("b2_pass", 32'(pass), 32'h0);
        step();

        // Zero patterns: straight to DONE
        num_patterns = 8'd0;
        start        = 1'b1;
        step();
        start = 1'b0;
        chk("c_done", 32'(done), 32'h1);
        chk("c_sig", 32'(signature), 32'h0);
        chk("c_stim", 32'(stim), 32'h0);
        chk("c_busy", 32'(busy), 32'h0);
        step();
        chk("c_done_pulse", 32'(done), 32'h0);
        chk("c_stim_idle", 32'(stim), 32'h0);

        // Maximum pattern count, zero response
        resp_tie     = 2'b00;
        seed         = 8'h5A;
        num_patterns = 8'd255;
        expected_sig = 16'h0000;
        start        = 1'b1;
        step();
        start = 1'b0;
        run_to_done(1, 400, c);
        chk("d_done", 32'(done), 32'h1);
        chk("d_latency", 32'(c), 32'(255 + LAT + 1));
        chk("d_sig", 32'(signature), 32'h0);
        chk("d_pass", 32'(pass), 32'h1);
        step();

        // Reset during the third RUN cycle aborts the run
        use_net      = 1'b1;
        seed         = 8'h01;
        num_patterns = 8'd4;
        expected_sig = 16'h000F;
        start        = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("e_pre_stim", 32'(stim), 32'hC);
        rst_n = 1'b0;
        step();
        chk("e_rst_stim", 32'(stim), 32'h0);
        chk("e_rst_busy", 32'(busy), 32'h0);
        chk("e_rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) nd++;
        end
        chk("e_no_done", 32'(nd), 32'h0);
        chk("e_idle_busy", 32'(busy), 32'h0);

        // Fresh run after abort; seed 0 falls back to 8'h01
        seed  = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("e2_stim0", 32'(stim), 32'h1);
        step();
        chk("e2_stim1", 32'(stim), 32'h8);
        step();
        chk("e2_stim2", 32'(stim), 32'hC);
        step();
        chk("e2_stim3", 32'(stim), 32'hE);
        run_to_done(4, 20, c);
        chk("e2_done", 32'(done), 32'h1);
        chk("e2_latency", 32'(c), 32'(4 + LAT + 1));
        chk("e2_sig", 32'(signature), 32'h000F);
        chk("e2_pass", 32'(pass), 32'h1);
        step();

        // start held high: back-to-back single-pattern runs
        use_net      = 1'b0;
        resp_tie     = 2'b01;
        seed         = 8'h07;
        num_patterns = 8'd1;
        expected_sig = 16'h0001;
        start        = 1'b1;
        nd = 0;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy) nb++;
            if (done) begin
                nd++;
                chk("f_sig", 32'(signature), 32'h0001);
                chk("f_pass", 32'(pass), 32'h1);
            end
        end
        chk("f_done_count", 32'(nd), 32'd4);
        chk("f_busy_count", 32'(nb), 32'd12);
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("f_idle_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
